dcache_dm: RTL and testbench

DCACHE_DM -- requirements
Module: dcache_dm

---
 rtl/dcache_dm.sv | 152 +++++++++++++++
 tb/tb_dcache_dm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// single outstanding backing-memory transaction.
module dcache_dm #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LINES   = 16,
   parameter logic [4:0]  STR_UOP = 5'b01001,
   parameter logic [4:0]  LDR_UOP = 5'b01010
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [4:0]        uop,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              flush,
   output logic              resp_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t              r_state;
   logic [LINES-1:0]    r_valid;
   logic [TAG_W-1:0]    r_tag  [LINES];
   logic [DATA_W-1:0]   r_data [LINES];

   logic                r_resp_valid;
   logic [DATA_W-1:0]   r_data_out;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;

   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [IDX_W-1:0]    w_fill_idx;
   logic [TAG_W-1:0]    w_fill_tag;
   logic                w_hit;
   logic                w_accept;
   logic                w_is_ldr;
   logic                w_is_str;
   logic                w_str_hit;
   logic                w_fill_done;

   // Address decode, hit detection and acceptance qualifiers.
   assign w_idx       = addr[IDX_W-1:0];
   assign w_tag       = addr[ADDR_W-1:IDX_W];
   assign w_fill_idx  = r_mem_addr[IDX_W-1:0];
   assign w_fill_tag  = r_mem_addr[ADDR_W-1:IDX_W];
   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign req_ready   = (r_state == IDLE) && !flush;
   assign w_accept    = req_valid && req_ready;
   assign w_is_ldr    = (uop == LDR_UOP);
   assign w_is_str    = (uop == STR_UOP);
   assign w_str_hit   = w_accept && w_is_str && w_hit;
   assign w_fill_done = (r_state == FILL) && mem_ack;

   assign resp_valid  = r_resp_valid;
   assign data_out    = r_data_out;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;

   // Tag/data arrays: store hits update data, fills write tag and data.
   // Valid bits are cleared during reset, so no hit or fill can occur then.
   always_ff @(posedge clock) begin
      if (w_str_hit) begin
         r_data[w_idx] <= data_in;
      end else if (w_fill_done) begin
         r_data[w_fill_idx] <= mem_rdata;
         r_tag[w_fill_idx]  <= w_fill_tag;
      end
   end

   // Controller FSM with registered response and memory-request outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_resp_valid <= 1'b0;
         r_data_out   <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (flush) begin
                  r_valid <= '0;
               end else if (w_accept && w_is_ldr) begin
                  if (w_hit) begin
                     r_data_out   <= r_data[w_idx];
                     r_resp_valid <= 1'b1;
                  end else begin
                     r_state    <= FILL;
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= addr;
                  end
               end else if (w_accept && w_is_str) begin
                  r_state     <= WRITE;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= addr;
                  r_mem_wdata <= data_in;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  r_valid[w_fill_idx] <= 1'b1;
                  r_data_out          <= mem_rdata;
                  r_resp_valid        <= 1'b1;
                  r_mem_req           <= 1'b0;
                  r_state             <= IDLE;
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  r_resp_valid <= 1'b1;
                  r_mem_req    <= 1'b0;
                  r_mem_we     <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: inputs change on the falling edge and
// outputs are sampled on the falling edge after each rising edge.
module tb_dcache_dm;

   localparam logic [4:0] LDR = 5'b01010;
   localparam logic [4:0] STR = 5'b01001;
   localparam logic [4:0] NOP = 5'b00000;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  uop;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic        flush;
   logic        resp_valid;
   logic [31:0] data_out;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_vec = 0;
   int n_err = 0;
   int req_cycles;

   dcache_dm dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .uop        (uop),
      .addr       (addr),
      .data_in    (data_in),
      .flush      (flush),
      .resp_valid (resp_valid),
      .data_out   (data_out),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clock = ~clock;

   // Count one comparison and report it if it misses.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic drive_req(input logic [4:0] u, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      uop       = u;
      addr      = a;
      data_in   = d;
   endtask

   task automatic ack_once(input logic [31:0] rd);
      mem_ack   = 1'b1;
      mem_rdata = rd;
      step();
      mem_ack   = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      uop       = NOP;
      addr      = '0;
      data_in   = '0;
      flush     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      #1;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_mem_req",    64'(mem_req),    64'd0);
      chk("rst_data_out",   64'(data_out),   64'd0);
      chk("rst_mem_addr",   64'(mem_addr),   64'd0);
      chk("rst_req_ready",  64'(req_ready),  64'd1);
      step();
      reset_n = 1'b1;
      step();

      // Cold load, memory answers after 3 wait cycles.
      drive_req(LDR, 32'h25, 32'h0);
      chk("cold_req_ready", 64'(req_ready), 64'd1);
      step();
      req_valid  = 1'b0;
      req_cycles = 0;
      chk("cold_mem_we",   64'(mem_we),   64'd0);
      chk("cold_mem_addr", 64'(mem_addr), 64'h25);
      chk("cold_ready_lo", 64'(req_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         if (mem_req) req_cycles++;
         chk("cold_no_resp", 64'(resp_valid), 64'd0);
         if (i == 3) ack_once(32'hDEADBEEF);
         else step();
      end
      chk("cold_req_cycles", 64'(req_cycles), 64'd4);
      chk("cold_resp",       64'(resp_valid), 64'd1);
      chk("cold_data",       64'(data_out),   64'hDEADBEEF);
      chk("cold_req_drop",   64'(mem_req),    64'd0);
      step();
      chk("cold_resp_pulse", 64'(resp_valid), 64'd0);

      // Repeat load hits.
      drive_req(LDR, 32'h25, 32'h0);
      step();
      req_valid = 1'b0;
      chk("hit_resp",   64'(resp_valid), 64'd1);
      chk("hit_data",   64'(data_out),   64'hDEADBEEF);
      chk("hit_no_mem", 64'(mem_req),    64'd0);
      step();
      chk("hit_resp_pulse", 64'(resp_valid), 64'd0);

      // Store hit, with a flush during WRITE that must be ignored.
      drive_req(STR, 32'h25, 32'h12345678);
      step();
      req_valid = 1'b0;
      chk("str_mem_req",   64'(mem_req),   64'd1);
      chk("str_mem_we",    64'(mem_we),    64'd1);
      chk("str_mem_addr",  64'(mem_addr),  64'h25);
      chk("str_mem_wdata", 64'(mem_wdata), 64'h12345678);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("str_flush_ign", 64'(mem_req), 64'd1);
      ack_once(32'hFFFF0000);
      chk("str_resp",      64'(resp_valid), 64'd1);
      chk("str_data_hold", 64'(data_out),   64'hDEADBEEF);
      chk("str_req_drop",  64'(mem_req),    64'd0);

      // Back-to-back load hits return the stored value each cycle.
      drive_req(LDR, 32'h25, 32'h0);
      step();
      chk("b2b_resp0", 64'(resp_valid), 64'd1);
      chk("b2b_data0", 64'(data_out),   64'h12345678);
      step();
      req_valid = 1'b0;
      chk("b2b_resp1", 64'(resp_valid), 64'd1);
      chk("b2b_mem1",  64'(mem_req),    64'd0);

      // Same index, different tag: evicts 0x25.
      drive_req(LDR, 32'h35, 32'h0);
      step();
      req_valid = 1'b0;
      chk("evict_miss", 64'(mem_req),  64'd1);
      chk("evict_addr", 64'(mem_addr), 64'h35);
      ack_once(32'hCAFEF00D);
      chk("evict_data", 64'(data_out), 64'hCAFEF00D);
      drive_req(LDR, 32'h25, 32'h0);
      step();
      req_valid = 1'b0;
      chk("reload_miss", 64'(mem_req),    64'd1);
      chk("reload_resp", 64'(resp_valid), 64'd0);
      ack_once(32'h12345678);
      chk("reload_data", 64'(data_out), 64'h12345678);

      // Unknown micro-op: nothing happens.
      drive_req(NOP, 32'h25, 32'h0);
      step();
      req_valid = 1'b0;
      chk("nop_resp", 64'(resp_valid), 64'd0);
      chk("nop_mem",  64'(mem_req),    64'd0);

      // Flush beats a simultaneous request; the line is then invalid.
      flush = 1'b1;
      drive_req(LDR, 32'h25, 32'h0);
      #1;
      chk("flush_ready", 64'(req_ready), 64'd0);
      step();
      flush     = 1'b0;
      req_valid = 1'b0;
      chk("flush_no_resp", 64'(resp_valid), 64'd0);
      chk("flush_no_mem",  64'(mem_req),    64'd0);
      drive_req(LDR, 32'h25, 32'h0);
      step();
      req_valid = 1'b0;
      chk("flush_miss", 64'(mem_req), 64'd1);
      ack_once(32'h12345678);
      chk("flush_fill_data", 64'(data_out), 64'h12345678);

      // Reset mid-fill, then a late acknowledge.
      drive_req(LDR, 32'h35, 32'h0);
      step();
      req_valid = 1'b0;
      chk("rf_mem_req", 64'(mem_req), 64'd1);
      step();
      #1;
      reset_n = 1'b0;
      #1;
      chk("rf_mem_req0",  64'(mem_req),   64'd0);
      chk("rf_mem_addr0", 64'(mem_addr),  64'd0);
      chk("rf_data_out0", 64'(data_out),  64'd0);
      chk("rf_resp0",     64'(resp_valid), 64'd0);
      step();
      reset_n = 1'b1;
      ack_once(32'h55555555);
      chk("rf_late_resp", 64'(resp_valid), 64'd0);
      chk("rf_late_data", 64'(data_out),   64'd0);
      drive_req(LDR, 32'h25, 32'h0);
      step();
      req_valid = 1'b0;
      chk("rf_post_miss", 64'(mem_req), 64'd1);
      ack_once(32'h12345678);
      chk("rf_post_data", 64'(data_out), 64'h12345678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
